// File: rtl/alu_nibble_sequencer_if.sv
// Request/response bundle between a client and alu_nibble_sequencer.
// Optional status outputs are present only with ALU_SEQ_STATUS_EN defined.
interface alu_nibble_sequencer_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [3:0]   s_in;
  logic         m_in;
  logic         cn_in;
  logic         busy;
  logic         done;
  logic [W-1:0] f_out;
  logic         cn_out;
  logic         aeqb_out;
`ifdef ALU_SEQ_STATUS_EN
  logic         zero_out;
  logic         neg_out;

  modport master (output start, a_in, b_in, s_in, m_in, cn_in,
                  input  busy, done, f_out, cn_out, aeqb_out, zero_out, neg_out);
  modport slave  (input  start, a_in, b_in, s_in, m_in, cn_in,
                  output busy, done, f_out, cn_out, aeqb_out, zero_out, neg_out);
`else
  modport master (output start, a_in, b_in, s_in, m_in, cn_in,
                  input  busy, done, f_out, cn_out, aeqb_out);
  modport slave  (input  start, a_in, b_in, s_in, m_in, cn_in,
                  output busy, done, f_out, cn_out, aeqb_out);
`endif
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Drives an external 4-bit combinational ALU one nibble per cycle to build a
// W-bit result, chaining the ALU carry unmodified between nibbles.
// Optional feature macro: ALU_SEQ_STATUS_EN (adds zero_out / neg_out).
module alu_nibble_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_nibble_sequencer_if.slave req,
  output logic [3:0]            alu_A,
  output logic [3:0]            alu_B,
  output logic [3:0]            alu_S,
  output logic                  alu_M,
  output logic                  alu_Cn,
  input  logic [3:0]            alu_F,
  input  logic                  alu_Cn4,
  input  logic                  alu_AeqB
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned SW = KW + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, f_q, f_d;
  logic [3:0]    s_q, s_d;
  logic          m_q, m_d;
  logic          eq_q, eq_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          cn_out_q, cn_out_d, aeqb_q, aeqb_d;
  logic [3:0]    alu_a_d, alu_b_d, alu_s_d;
  logic          alu_m_d, alu_cn_d;
  logic [SW-1:0] sh_cur, sh_nxt;
`ifdef ALU_SEQ_STATUS_EN
  logic          zero_q, zero_d, neg_q, neg_d;
`endif

  // Bit offsets of the current and the following nibble
  assign sh_cur = {k_q, 2'b00};
  assign sh_nxt = {k_q + KW'(1), 2'b00};

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    m_d      = m_q;
    eq_d     = eq_q;
    f_d      = f_q;
    cn_out_d = cn_out_q;
    aeqb_d   = aeqb_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    alu_a_d  = 4'h0;
    alu_b_d  = 4'h0;
    alu_s_d  = 4'h0;
    alu_m_d  = 1'b0;
    alu_cn_d = 1'b0;
`ifdef ALU_SEQ_STATUS_EN
    zero_d   = zero_q;
    neg_d    = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req.start) begin
          state_d  = RUN;
          k_d      = '0;
          a_d      = req.a_in;
          b_d      = req.b_in;
          s_d      = req.s_in;
          m_d      = req.m_in;
          eq_d     = 1'b1;
          f_d      = '0;
          busy_d   = 1'b1;
          alu_a_d  = req.a_in[3:0];
          alu_b_d  = req.b_in[3:0];
          alu_s_d  = req.s_in;
          alu_m_d  = req.m_in;
          alu_cn_d = req.cn_in;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        f_d    = (f_q & ~(W'(4'hF) << sh_cur)) | (W'(alu_F) << sh_cur);
        eq_d   = eq_q & alu_AeqB;
        if (k_q == KW'(NIBBLES - 1)) begin
          state_d  = DONE;
          done_d   = 1'b1;
          cn_out_d = alu_Cn4;
          aeqb_d   = eq_d;
`ifdef ALU_SEQ_STATUS_EN
          zero_d   = (f_d == '0);
          neg_d    = f_d[W-1];
`endif
        end else begin
          k_d      = k_q + KW'(1);
          alu_a_d  = 4'(a_q >> sh_nxt);
          alu_b_d  = 4'(b_q >> sh_nxt);
          alu_s_d  = s_q;
          alu_m_d  = m_q;
          alu_cn_d = alu_Cn4;
        end
      end
      DONE: begin
        state_d = IDLE;
        k_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= 4'h0;
      m_q      <= 1'b0;
      eq_q     <= 1'b0;
      f_q      <= '0;
      cn_out_q <= 1'b0;
      aeqb_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      alu_A    <= 4'h0;
      alu_B    <= 4'h0;
      alu_S    <= 4'h0;
      alu_M    <= 1'b0;
      alu_Cn   <= 1'b0;
`ifdef ALU_SEQ_STATUS_EN
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      eq_q     <= eq_d;
      f_q      <= f_d;
      cn_out_q <= cn_out_d;
      aeqb_q   <= aeqb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      alu_A    <= alu_a_d;
      alu_B    <= alu_b_d;
      alu_S    <= alu_s_d;
      alu_M    <= alu_m_d;
      alu_Cn   <= alu_cn_d;
`ifdef ALU_SEQ_STATUS_EN
      zero_q   <= zero_d;
      neg_q    <= neg_d;
`endif
    end
  end

  assign req.busy     = busy_q;
  assign req.done     = done_q;
  assign req.f_out    = f_q;
  assign req.cn_out   = cn_out_q;
  assign req.aeqb_out = aeqb_q;
`ifdef ALU_SEQ_STATUS_EN
  assign req.zero_out = zero_q;
  assign req.neg_out  = neg_q;
`endif

endmodule
